fifo_rd_sched: RTL and testbench
================================

Name: fifo_rd_sched

Overview:
- Read-side scheduler for the multi-channel packet FIFO (fifo_p family).
- Three ingress channels (a/b/c) have already been width-converted to 16-bit words and written into per-channel data FIFOs and packet-info FIFOs.
- This block arbitrates round-robin among channels holding a complete packet and drains one whole packet at a time onto the shared data_d bus, tagging it with chan_d.
- It runs entirely in the clk_d (output) domain.

Parameters:
- DATA_W, 16, payload width of data_d and of each FIFO word.
- GAP_CYC, 2, idle cycles forced between packets (1..15).
- TO_CYC, 64, consecutive dat_empty cycles inside a packet before abort (2..255).

Ports:
- clk  in  1  clk_d domain clock.
- rst_n  in  1  synchronous, active-low reset.
- pkt_empty  in  3  per-channel packet-info FIFO empty; bit n=0 means channel n holds at least one complete packet.
- pkt_rdreq  out  3  one-cycle pop of channel n packet-info entry at packet start.
- dat_empty  in  3  per-channel data FIFO empty.
- dat_q  in  3*(DATA_W+2)  per-channel show-ahead FIFO head.
  - Channel n occupies bits [(n+1)*18-1 : n*18] at default width.
  - Word layout: {eop, mty, data}.
- dat_rdreq  out  3  per-channel data FIFO pop.
- data_d  out  DATA_W  output word.
- data_d_vld  out  1  data_d valid.
- data_d_sop  out  1  first word of packet.
- data_d_eop  out  1  last word of packet.
- data_d_mty  out  1  on eop: 1 means only the upper byte is valid.
- chan_d  out  2  source channel of the current word: 0=a, 1=b, 2=c.
- err_to  out  1  one-cycle pulse when a packet is aborted on timeout.

Behaviour:
- Reset, synchronous on rst_n=0: all outputs 0, state=IDLE, last_grant=2 (channel 0 wins first), all counters 0. Asserting reset mid-packet abandons the packet immediately; there is no eop and no partial flush.
- States: IDLE, START, READ, GAP.
- IDLE:
  - If req = ~pkt_empty is nonzero, choose the first requesting channel in the order last_grant+1, +2, +3 (mod 3).
  - Register grant g and go to START.
- START (exactly 1 cycle):
  - pkt_rdreq[g]=1.
  - Set the first-word flag.
  - Update last_grant=g.
  - Go to READ.
- READ:
  - dat_rdreq[g] = ~dat_empty[g], combinational from the registered state. No other bit of dat_rdreq is ever high.
  - When dat_rdreq[g]=1 and dat_q[g].eop=1, the packet ends; go to GAP next cycle.
- Output pipeline: a 1-cycle register stage from dat_rdreq.
  - data_d_vld <= dat_rdreq[g].
  - data_d <= dat_q[g].data.
  - data_d_sop <= rdreq & first; the first flag clears on the first pop.
  - data_d_eop <= rdreq & q.eop.
  - data_d_mty <= rdreq & q.eop & q.mty.
  - chan_d <= g while vld; chan_d holds its last value when vld=0.
- Single-word packet: sop and eop are both 1 in the same cycle.
- Underflow holes: if dat_empty[g]=1 in READ, no pop occurs and vld=0 that cycle. A timeout counter increments on each empty cycle and clears on any pop.
- Timeout: when the counter reaches TO_CYC, err_to=1 for 1 cycle, then go to GAP with no eop emitted. The remainder of the packet stays in the FIFO.
- GAP: hold for GAP_CYC cycles (counter), then go to IDLE.
  - Minimum spacing from the eop output to the next sop output is GAP_CYC+3 cycles (GAP, IDLE, START, first-pop register).
- Ignored inputs: pkt_empty changes during START/READ/GAP are ignored, and non-granted channels are never popped.
- Arbitration holds only between packets; a packet is never interleaved with another.

Decomposition:
- Package fifo_sched_pkg holds:
  - CHAN_NUM=3.
  - Word field indices EOP_BIT=DATA_W+1, MTY_BIT=DATA_W.
  - State encoding (IDLE/START/READ/GAP).
  - Channel codes CH_A=0, CH_B=1, CH_C=2.
- Sub-module rr_arb3: 3-way round-robin arbiter. It takes req[2:0] and last_grant[1:0], and returns grant[1:0] plus any_req, combinationally. The pointer register stays in fifo_rd_sched.

Test Plan:
1. After reset, only channel 1 ready, 4 words D0..D3 with mty=1 on D3 -> pkt_rdreq=3'b010 for 1 cycle; 4 consecutive vld words D0..D3 with chan_d=1; sop on D0; eop and mty=1 on D3; err_to=0.
2. All three channels ready at once, 3 words each -> packets emitted in order chan 0, 1, 2; no interleaving; eop to next sop = GAP_CYC+3 = 5 cycles.
3. Channel 2 single-word packet 16'hA5A5 -> one vld cycle with sop=eop=1, chan_d=2, data_d=16'hA5A5.
4. Channel 0 packet of 5 words with dat_empty high for 3 cycles after word 2 -> vld low for exactly 3 cycles; words in order; sop only once; eop on word 5.
5. Channel 1 packet stalls, dat_empty stuck high after word 1 with TO_CYC=64 -> err_to pulses once 64 cycles after the last pop; no eop; next arbitration serves channel 2 before channel 1.
6. rst_n low for 1 cycle in the middle of a channel-2 packet -> next cycle all outputs 0, state IDLE; with all channels then ready, channel 0 is granted first.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared constants, types and helpers for the fifo_p read-side scheduler.
package fifo_sched_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WORD_W   = DATA_W + 2;
  localparam int unsigned CHAN_NUM = 3;

  // Field positions inside one FIFO word {eop, mty, data}
  localparam int unsigned EOP_BIT = DATA_W + 1;
  localparam int unsigned MTY_BIT = DATA_W;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic              eop;
    logic              mty;
    logic [DATA_W-1:0] data;
  } word_t;

  // One-hot channel mask for a channel code
  function automatic logic [CHAN_NUM-1:0] chan_onehot(input logic [1:0] ch);
    case (ch)
      CH_A:    return 3'b001;
      CH_B:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin arbiter; the pointer lives in the caller.
module rr_arb3
  import fifo_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       any_req
);

  // Search order starts at the channel after last_grant
  always_comb begin
    any_req = |req;
    grant   = CH_A;
    case (last_grant)
      CH_A: begin
        if (req[1])      grant = CH_B;
        else if (req[2]) grant = CH_C;
        else if (req[0]) grant = CH_A;
      end
      CH_B: begin
        if (req[2])      grant = CH_C;
        else if (req[0]) grant = CH_A;
        else if (req[1]) grant = CH_B;
      end
      default: begin
        if (req[0])      grant = CH_A;
        else if (req[1]) grant = CH_B;
        else if (req[2]) grant = CH_C;
      end
    endcase
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Drains whole packets from three channel FIFOs onto one bus, round-robin.
module fifo_rd_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TO_CYC  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHAN_NUM-1:0]        pkt_empty,
  output logic [CHAN_NUM-1:0]        pkt_rdreq,
  input  logic [CHAN_NUM-1:0]        dat_empty,
  input  logic [CHAN_NUM*WORD_W-1:0] dat_q,
  output logic [CHAN_NUM-1:0]        dat_rdreq,
  output logic [DATA_W-1:0]          data_d,
  output logic                       data_d_vld,
  output logic                       data_d_sop,
  output logic                       data_d_eop,
  output logic                       data_d_mty,
  output logic [1:0]                 chan_d,
  output logic                       err_to
);

  localparam int unsigned TO_W  = 8;
  localparam int unsigned GAP_W = 4;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic               first_q, first_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               err_to_d;

  logic [CHAN_NUM-1:0] req;
  logic [1:0]          arb_grant;
  logic                arb_any;
  logic [CHAN_NUM-1:0] sel_oh;
  logic [WORD_W-1:0]   head;
  logic                head_eop;
  logic                head_mty;
  logic                sel_empty;
  logic                rd;

  assign req = ~pkt_empty;

  rr_arb3 u_arb (
    .req        (req),
    .last_grant (last_q),
    .grant      (arb_grant),
    .any_req    (arb_any)
  );

  // Pick the granted channel's FIFO head and empty flag
  always_comb begin
    sel_oh = chan_onehot(grant_q);
    case (grant_q)
      CH_A:    head = dat_q[WORD_W-1:0];
      CH_B:    head = dat_q[2*WORD_W-1:WORD_W];
      default: head = dat_q[3*WORD_W-1:2*WORD_W];
    endcase
    head_eop  = head[EOP_BIT];
    head_mty  = head[MTY_BIT];
    sel_empty = |(dat_empty & sel_oh);
  end

  // Next-state, counters and FIFO pop strobes
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    first_d   = first_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    err_to_d  = 1'b0;
    pkt_rdreq = '0;
    dat_rdreq = '0;
    rd        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          state_d = ST_START;
        end
      end
      ST_START: begin
        pkt_rdreq = sel_oh;
        first_d   = 1'b1;
        last_d    = grant_q;
        to_cnt_d  = '0;
        state_d   = ST_READ;
      end
      ST_READ: begin
        rd        = ~sel_empty;
        dat_rdreq = rd ? sel_oh : '0;
        if (rd) begin
          to_cnt_d = '0;
          first_d  = 1'b0;
          if (head_eop) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
          // Data never arrived: abandon the packet, the rest stays queued
          err_to_d  = 1'b1;
          to_cnt_d  = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; last_q starts at C so A wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= CH_A;
      last_q    <= CH_C;
      first_q   <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      err_to    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      first_q   <= first_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_to    <= err_to_d;
    end
  end

  // One-cycle output stage registered from the pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_d     <= '0;
      data_d_vld <= 1'b0;
      data_d_sop <= 1'b0;
      data_d_eop <= 1'b0;
      data_d_mty <= 1'b0;
      chan_d     <= '0;
    end else begin
      data_d     <= head[DATA_W-1:0];
      data_d_vld <= rd;
      data_d_sop <= rd & first_q;
      data_d_eop <= rd & head_eop;
      data_d_mty <= rd & head_eop & head_mty;
      if (rd) begin
        chan_d <= grant_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Randomised scoreboard bench for fifo_rd_sched with a packet-level model.
module tb_fifo_rd_sched;
  import fifo_sched_pkg::*;

  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned TO_CYC  = 64;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [CHAN_NUM-1:0]        pkt_empty;
  logic [CHAN_NUM-1:0]        pkt_rdreq;
  logic [CHAN_NUM-1:0]        dat_empty;
  logic [CHAN_NUM*WORD_W-1:0] dat_q;
  logic [CHAN_NUM-1:0]        dat_rdreq;
  logic [DATA_W-1:0]          data_d;
  logic                       data_d_vld, data_d_sop, data_d_eop, data_d_mty;
  logic [1:0]                 chan_d;
  logic                       err_to;

  fifo_rd_sched #(.GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_empty(pkt_empty), .pkt_rdreq(pkt_rdreq),
    .dat_empty(dat_empty), .dat_q(dat_q), .dat_rdreq(dat_rdreq),
    .data_d(data_d), .data_d_vld(data_d_vld), .data_d_sop(data_d_sop),
    .data_d_eop(data_d_eop), .data_d_mty(data_d_mty),
    .chan_d(chan_d), .err_to(err_to)
  );

  always #5 clk = ~clk;

  // hole = cycles the data FIFO looks empty after this word is popped
  typedef struct {
    logic [DATA_W-1:0] data;
    bit                eop;
    bit                mty;
    int                hole;
  } fword_t;

  typedef struct {
    bit                is_to;
    logic [DATA_W-1:0] data;
    bit                sop;
    bit                eop;
    bit                mty;
    logic [1:0]        chan;
    int                gap;
  } exp_t;

  fword_t fifo_q[3][$];
  int     pkt_cnt[3];
  int     block[3];
  fword_t ref_words[3][$];
  int     ref_len[3][$];
  int     ref_stall[3][$];
  int     ref_last;
  exp_t   sb[$];

  int checks = 0;
  int fails  = 0;
  int cyc = 0, last_vld_cyc = 0, end_cyc = 0;
  bit end_valid = 0;
  logic [1:0] last_chan = 2'd0;

  function automatic void drive();
    logic [WORD_W-1:0] wv;
    for (int n = 0; n < 3; n++) begin
      pkt_empty[n] = (pkt_cnt[n] == 0);
      dat_empty[n] = (fifo_q[n].size() == 0) || (block[n] > 0);
      wv = '0;
      if (fifo_q[n].size() > 0) begin
        wv[EOP_BIT]        = fifo_q[n][0].eop;
        wv[MTY_BIT]        = fifo_q[n][0].mty;
        wv[DATA_W-1:0]     = fifo_q[n][0].data;
      end
      dat_q[n*WORD_W +: WORD_W] = wv;
    end
  endfunction

  function automatic void flush();
    for (int n = 0; n < 3; n++) begin
      fifo_q[n].delete(); ref_words[n].delete();
      ref_len[n].delete(); ref_stall[n].delete();
      pkt_cnt[n] = 0; block[n] = 0;
    end
    sb.delete();
    ref_last = 2;
  endfunction

  // Queue one packet into the channel FIFO model and the reference copy
  function automatic void add_pkt(input int ch, input int len, input int base,
                                  input int hole_idx, input int hole_len,
                                  input int stall, input bit last_mty);
    fword_t w;
    for (int i = 0; i < len; i++) begin
      w.data = (base >= 0) ? DATA_W'(base + i) : DATA_W'($urandom);
      w.eop  = (i == len - 1);
      w.mty  = (i == len - 1) ? last_mty : bit'($urandom_range(1));
      w.hole = (i == hole_idx) ? hole_len : 0;
      if (i == stall) w.hole = 1000000;
      fifo_q[ch].push_back(w);
      ref_words[ch].push_back(w);
    end
    pkt_cnt[ch]++;
    ref_len[ch].push_back(len);
    ref_stall[ch].push_back(stall);
  endfunction

  // Packet-level model: round-robin over pending channels, whole packets only
  function automatic void predict();
    exp_t e;
    fword_t w;
    int c, len, st, prev_hole;
    while (ref_len[0].size() + ref_len[1].size() + ref_len[2].size() > 0) begin
      c = -1;
      for (int k = 1; k <= 3; k++)
        if (c < 0 && ref_len[(ref_last + k) % 3].size() > 0) c = (ref_last + k) % 3;
      len = ref_len[c].pop_front();
      st  = ref_stall[c].pop_front();
      prev_hole = 0;
      for (int i = 0; i < len; i++) begin
        w = ref_words[c].pop_front();
        if (st < 0 || i <= st) begin
          e.is_to = 0; e.data = w.data; e.sop = (i == 0);
          e.eop = (st < 0) && w.eop; e.mty = e.eop && w.mty;
          e.chan = 2'(c); e.gap = prev_hole;
          sb.push_back(e);
        end
        prev_hole = w.hole;
      end
      if (st >= 0) begin
        e.is_to = 1; e.data = '0; e.sop = 0; e.eop = 0; e.mty = 0;
        e.chan = 2'(c); e.gap = 0;
        sb.push_back(e);
      end
      ref_last = c;
    end
  endfunction

  // FIFO model: act on pops seen before the edge, then present new heads
  initial begin : fifo_model
    logic [2:0] pr, dr, de;
    fword_t w;
    flush();
    drive();
    forever begin
      @(negedge clk);
      pr = pkt_rdreq; dr = dat_rdreq; de = dat_empty;
      if (dr != 3'b000) begin
        checks++;
        if ((dr & de) != 3'b000 || $countones(dr) > 1) begin
          fails++;
          $display("FAIL dat_pop: dat_rdreq=%b dat_empty=%b, required one-hot pop of a non-empty FIFO", dr, de);
        end
      end
      if (pr != 3'b000) begin
        checks++;
        if ($countones(pr) > 1 || (pr[0] && pkt_cnt[0] == 0) ||
            (pr[1] && pkt_cnt[1] == 0) || (pr[2] && pkt_cnt[2] == 0)) begin
          fails++;
          $display("FAIL pkt_pop: pkt_rdreq=%b pkt_empty=%b, required one-hot pop of a held packet", pr, pkt_empty);
        end
      end
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) begin
        if (block[n] > 0) block[n]--;
        if (pr[n] && pkt_cnt[n] > 0) pkt_cnt[n]--;
        if (dr[n] && fifo_q[n].size() > 0) begin
          w = fifo_q[n].pop_front();
          block[n] = w.hole;
        end
      end
      #1;
      drive();
    end
  end

  // Monitor: pop expected entries whenever the DUT emits a word or an abort
  initial begin : monitor
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_chan = 2'd0;
        end_valid = 0;
      end else if (data_d_vld || err_to) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: vld=%0b err_to=%0b data=%h chan=%0d, required no output", data_d_vld, err_to, data_d, chan_d);
        end else begin
          e = sb.pop_front();
          if (e.is_to)
            ok = err_to && !data_d_vld && (cyc - last_vld_cyc == int'(TO_CYC));
          else
            ok = data_d_vld && !err_to && (data_d === e.data) && (data_d_sop === e.sop) &&
                 (data_d_eop === e.eop) && (data_d_mty === e.mty) && (chan_d === e.chan) &&
                 (e.sop || (cyc - last_vld_cyc == e.gap + 1));
          if (!e.is_to && e.sop && end_valid)
            ok = ok && (cyc - end_cyc == int'(GAP_CYC) + 3);
          if (!ok) begin
            fails++;
            $display("FAIL sb_item: got vld=%0b to=%0b data=%h sop=%0b eop=%0b mty=%0b chan=%0d since_vld=%0d since_end=%0d; required to=%0b data=%h sop=%0b eop=%0b mty=%0b chan=%0d hole=%0d",
                     data_d_vld, err_to, data_d, data_d_sop, data_d_eop, data_d_mty, chan_d,
                     cyc - last_vld_cyc, cyc - end_cyc, e.is_to, e.data, e.sop, e.eop, e.mty, e.chan, e.gap);
          end
          if (!e.is_to && e.sop) end_valid = 0;
          if (e.is_to || e.eop) begin
            end_cyc   = cyc;
            end_valid = (sb.size() > 0);
          end
        end
        if (data_d_vld) begin
          last_vld_cyc = cyc;
          last_chan    = chan_d;
        end
      end else begin
        checks++;
        if (chan_d !== last_chan || data_d_sop || data_d_eop || data_d_mty) begin
          fails++;
          $display("FAIL idle_outs: chan=%0d sop=%0b eop=%0b mty=%0b, required chan=%0d and flags 0", chan_d, data_d_sop, data_d_eop, data_d_mty, last_chan);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (data_d_vld || data_d_sop || data_d_eop || data_d_mty || err_to ||
        data_d != '0 || chan_d != 2'd0 || pkt_rdreq != 3'b000 || dat_rdreq != 3'b000) begin
      fails++;
      $display("FAIL %s: vld=%0b sop=%0b eop=%0b mty=%0b to=%0b data=%h chan=%0d pkt_rdreq=%b dat_rdreq=%b, required all 0",
               name, data_d_vld, data_d_sop, data_d_eop, data_d_mty, err_to, data_d, chan_d, pkt_rdreq, dat_rdreq);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    flush();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && !data_d_vld)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; fails++;
      $display("FAIL drain_timeout: %0d items still pending, required 0", sb.size());
      sb.delete();
    end
    repeat (GAP_CYC + 3) @(negedge clk);
    checks++;
    if (pkt_cnt[0] + pkt_cnt[1] + pkt_cnt[2] != 0) begin
      fails++;
      $display("FAIL pkt_info_left: %0d/%0d/%0d entries, required 0/0/0", pkt_cnt[0], pkt_cnt[1], pkt_cnt[2]);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int found;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    // Channel 1 alone, 4 words, mty on the last
    @(posedge clk); #1;
    add_pkt(1, 4, 'hD0, -1, 0, -1, 1'b1);
    predict();
    wait_drain(200);

    // All three channels at once from a fresh pointer: order 0,1,2
    do_reset();
    @(posedge clk); #1;
    add_pkt(0, 3, -1, -1, 0, -1, 1'b0);
    add_pkt(1, 3, -1, -1, 0, -1, 1'b1);
    add_pkt(2, 3, -1, -1, 0, -1, 1'b0);
    predict();
    wait_drain(300);

    // Single-word packet on channel 2
    add_pkt(2, 1, 'hA5A5, -1, 0, -1, 1'b0);
    predict();
    wait_drain(200);

    // Channel 0, 5 words, 3-cycle underflow hole after word 2
    add_pkt(0, 5, 'h100, 1, 3, -1, 1'b0);
    predict();
    wait_drain(200);

    // Channel 1 stalls after word 1 and times out; channel 2 follows
    add_pkt(1, 4, 'h200, -1, 0, 0, 1'b0);
    add_pkt(2, 3, 'h300, -1, 0, -1, 1'b1);
    predict();
    wait_drain(600);

    // Reset in the middle of a channel-2 packet
    add_pkt(2, 12, -1, -1, 0, -1, 1'b0);
    predict();
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (data_d_vld && data_d_sop && chan_d == 2'd2) found = 1;
    end
    checks++;
    if (found == 0) begin
      fails++;
      $display("FAIL ch2_start: no sop on channel 2 within 100 cycles, required one");
    end
    repeat (2) @(negedge clk);
    do_reset();
    @(negedge clk);
    check_zero("mid_pkt_reset");
    @(posedge clk); #1;
    add_pkt(0, 2, -1, -1, 0, -1, 1'b1);
    add_pkt(1, 2, -1, -1, 0, -1, 1'b0);
    add_pkt(2, 2, -1, -1, 0, -1, 1'b1);
    predict();
    wait_drain(300);

    // Random batches
    for (int b = 0; b < 25; b++) begin
      int np;
      np = 0;
      for (int ch = 0; ch < 3; ch++) begin
        int cnt;
        cnt = $urandom_range(2);
        for (int p = 0; p < cnt; p++) begin
          int len;
          len = $urandom_range(6, 1);
          add_pkt(ch, len, -1, (len > 1) ? $urandom_range(len - 2) : -1,
                  $urandom_range(3), -1, bit'($urandom_range(1)));
          np++;
        end
      end
      if (np == 0) add_pkt($urandom_range(2), $urandom_range(6, 1), -1, -1, 0, -1, 1'b0);
      predict();
      wait_drain(2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
